// File: rtl/system_unit.sv
// Execute-stage SYSTEM unit: cycle/time/instret counters, counter reads, SCALL/SBREAK trap request.
// Define SYSUNIT_INHIBIT_EN to add i_cnt_inhibit {instret, time, cycle} per-counter freeze controls.
module system_unit #(
    parameter int unsigned TIME_DIV  = 16,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_sysop,
    input  logic        i_retire,
`ifdef SYSUNIT_INHIBIT_EN
    input  logic [2:0]  i_cnt_inhibit,
`endif
    output logic [31:0] o_result,
    output logic        o_result_vld,
    output logic        o_trap,
    output logic        o_trap_cause,
    input  logic        i_trap_ack
);

    // t_sysop encoding shared with the decoder
    localparam logic [3:0] SysopScall      = 4'd0;
    localparam logic [3:0] SysopSbreak     = 4'd1;
    localparam logic [3:0] SysopRdcycle    = 4'd2;
    localparam logic [3:0] SysopRdcycleh   = 4'd3;
    localparam logic [3:0] SysopRdtime     = 4'd4;
    localparam logic [3:0] SysopRdtimeh    = 4'd5;
    localparam logic [3:0] SysopRdinstret  = 4'd6;
    localparam logic [3:0] SysopRdinstreth = 4'd7;

    localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);
    localparam logic [15:0]          PrescLast = 16'(TIME_DIV - 1);

    typedef enum logic {StIdle, StTrap} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cycle_q, time_q, instret_q;
    logic [15:0]          presc_q;
    logic [31:0]          result_q, rd_data;
    logic                 result_vld_q, trap_cause_q;
    logic                 accept, is_trap_op;
    logic                 inh_cycle, inh_time, inh_instret;

`ifdef SYSUNIT_INHIBIT_EN
    assign {inh_instret, inh_time, inh_cycle} = i_cnt_inhibit;
`else
    assign {inh_instret, inh_time, inh_cycle} = 3'b000;
`endif

    always_comb begin
        state_d    = state_q;
        o_ready    = (state_q == StIdle);
        accept     = i_valid && (state_q == StIdle);
        is_trap_op = (i_sysop == SysopScall) || (i_sysop == SysopSbreak);

        // Unknown encodings fall back to RDCYCLE, like the decoder default
        case (i_sysop)
            SysopRdcycleh:   rd_data = cycle_q[CNT_WIDTH-1:32];
            SysopRdtime:     rd_data = time_q[31:0];
            SysopRdtimeh:    rd_data = time_q[CNT_WIDTH-1:32];
            SysopRdinstret:  rd_data = instret_q[31:0];
            SysopRdinstreth: rd_data = instret_q[CNT_WIDTH-1:32];
            SysopRdcycle:    rd_data = cycle_q[31:0];
            default:         rd_data = cycle_q[31:0];
        endcase

        case (state_q)
            StIdle:  if (accept && is_trap_op) state_d = StTrap;
            StTrap:  if (i_trap_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cycle_q      <= '0;
            time_q       <= '0;
            instret_q    <= '0;
            presc_q      <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            trap_cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!inh_cycle) cycle_q <= cycle_q + CntOne;
            if (!inh_time) begin
                if (presc_q == PrescLast) begin
                    presc_q <= '0;
                    time_q  <= time_q + CntOne;
                end else begin
                    presc_q <= presc_q + 16'd1;
                end
            end
            if (i_retire && !inh_instret) instret_q <= instret_q + CntOne;
            // Reads sample the pre-increment counter value of the accept cycle
            result_vld_q <= accept && !is_trap_op;
            if (accept && !is_trap_op) result_q <= rd_data;
            if (accept && is_trap_op) trap_cause_q <= (i_sysop == SysopSbreak);
        end
    end

    assign o_result     = result_q;
    assign o_result_vld = result_vld_q;
    assign o_trap       = (state_q == StTrap);
    assign o_trap_cause = trap_cause_q;

endmodule

// File: tb/tb_system_unit.sv
// Directed bench for system_unit: two instances (TIME_DIV=4 and TIME_DIV=1) share all inputs.
// Exercises the SYSUNIT_INHIBIT_EN freeze controls when that macro is defined.
module tb_system_unit;

    localparam logic [3:0] OpScall      = 4'd0;
    localparam logic [3:0] OpSbreak     = 4'd1;
    localparam logic [3:0] OpRdcycle    = 4'd2;
    localparam logic [3:0] OpRdcycleh   = 4'd3;
    localparam logic [3:0] OpRdtime     = 4'd4;
    localparam logic [3:0] OpRdtimeh    = 4'd5;
    localparam logic [3:0] OpRdinstret  = 4'd6;
    localparam logic [3:0] OpRdinstreth = 4'd7;

    logic        clk = 1'b0;
    logic        rst, valid, retire, ack;
    logic [3:0]  sysop;
    logic [2:0]  inhibit;
    logic        ready, vld, trap, cause;
    logic [31:0] result;
    logic        ready1, vld1, trap1, cause1;
    logic [31:0] result1;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [63:0] exp_v;

    always #5 clk = ~clk;

    system_unit #(.TIME_DIV(4), .CNT_WIDTH(64)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_sysop      (sysop),
        .i_retire     (retire),
`ifdef SYSUNIT_INHIBIT_EN
        .i_cnt_inhibit(inhibit),
`endif
        .o_result     (result),
        .o_result_vld (vld),
        .o_trap       (trap),
        .o_trap_cause (cause),
        .i_trap_ack   (ack)
    );

    system_unit #(.TIME_DIV(1), .CNT_WIDTH(64)) dut1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .o_ready      (ready1),
        .i_sysop      (sysop),
        .i_retire     (retire),
`ifdef SYSUNIT_INHIBIT_EN
        .i_cnt_inhibit(inhibit),
`endif
        .o_result     (result1),
        .o_result_vld (vld1),
        .o_trap       (trap1),
        .o_trap_cause (cause1),
        .i_trap_ack   (ack)
    );

    // n tracks running cycle-counter edges since the last reset
    task automatic tick;
        @(posedge clk);
        if (rst) n = 0;
        else n = n + 1;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sysop = OpRdcycle; retire = 1'b0; ack = 1'b0; inhibit = 3'b000;
        repeat (5) tick;
        check("rst_result", 64'(result), 64'd0);
        check("rst_vld", 64'(vld), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_cause", 64'(cause), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_ready1", 64'(ready1), 64'd1);
        check("rst_trap1", 64'(trap1 | cause1 | vld1), 64'd0);

        // RDCYCLE accepted in the 10th post-reset cycle
        rst = 1'b0;
        repeat (9) tick;
        valid = 1'b1; sysop = OpRdcycle;
        tick;
        check("rdcycle_10th", 64'(result), 64'd9);
        check("rdcycle_10th_vld", 64'(vld), 64'd1);
        check("rdcycle_10th_div1", 64'(result1), 64'd9);
        valid = 1'b0;
        tick;
        check("vld_pulse_end", 64'(vld), 64'd0);

        // Time after 40 cycles: TIME_DIV=4 -> 10, TIME_DIV=1 -> 40
        while (n < 40) tick;
        valid = 1'b1; sysop = OpRdtime;
        tick;
        check("rdtime_div4", 64'(result), 64'd10);
        check("rdtime_div1", 64'(result1), 64'd40);
        sysop = OpRdtimeh;
        tick;
        check("rdtimeh", 64'(result), 64'd0);
        check("rdtimeh_vld", 64'(vld), 64'd1);
        sysop = OpRdcycle;
        tick;
        check("rdcycle_b2b", 64'(result), 64'd42);
        check("rdcycle_b2b_vld", 64'(vld), 64'd1);
        sysop = 4'hF;
        tick;
        check("illegal_as_rdcycle", 64'(result), 64'd43);
        sysop = OpRdcycleh;
        tick;
        check("rdcycleh", 64'(result), 64'd0);
        valid = 1'b0;

        // Instret: retire for 7 cycles, read in the 7th
        retire = 1'b1;
        repeat (6) tick;
        valid = 1'b1; sysop = OpRdinstret;
        tick;
        check("rdinstret_same_cycle", 64'(result), 64'd6);
        valid = 1'b0; retire = 1'b0;
        tick;
        valid = 1'b1;
        tick;
        check("rdinstret_later", 64'(result), 64'd7);
        sysop = OpRdinstreth;
        tick;
        check("rdinstreth", 64'(result), 64'd0);
        valid = 1'b0;
        tick;

        // SBREAK trap; requests while trapped are not accepted
        valid = 1'b1; sysop = OpSbreak;
        tick;
        check("sbreak_trap", 64'(trap), 64'd1);
        check("sbreak_cause", 64'(cause), 64'd1);
        check("sbreak_ready", 64'(ready), 64'd0);
        check("sbreak_no_vld", 64'(vld), 64'd0);
        sysop = OpRdcycle; retire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("trap_no_accept", 64'(vld), 64'd0);
            check("trap_held", 64'(trap), 64'd1);
        end
        retire = 1'b0; valid = 1'b0; ack = 1'b1;
        tick;
        check("ack_trap_clr", 64'(trap), 64'd0);
        check("ack_ready", 64'(ready), 64'd1);
        tick;
        check("ack_idle_ignored", 64'(trap), 64'd0);
        check("ack_idle_ready", 64'(ready), 64'd1);
        ack = 1'b0;
        valid = 1'b1; sysop = OpRdinstret;
        tick;
        check("instret_counted_in_trap", 64'(result), 64'd10);
        sysop = OpRdcycle;
        exp_v = 64'(n);
        tick;
        check("cycle_ran_in_trap", 64'(result), exp_v);

        // SCALL trap, then reset while trapped
        sysop = OpScall;
        tick;
        check("scall_trap", 64'(trap), 64'd1);
        check("scall_cause", 64'(cause), 64'd0);
        valid = 1'b0; rst = 1'b1;
        tick;
        check("rst_in_trap", 64'(trap), 64'd0);
        check("rst_in_trap_ready", 64'(ready), 64'd1);
        check("rst_in_trap_result", 64'(result), 64'd0);
        rst = 1'b0;
        valid = 1'b1; sysop = OpRdcycle;
        tick;
        check("cycle_zero_after_rst", 64'(result), 64'd0);
        sysop = OpRdinstret;
        tick;
        check("instret_zero_after_rst", 64'(result), 64'd0);
        sysop = OpRdtime;
        tick;
        check("time_after_rst_div4", 64'(result), 64'd0);
        check("time_after_rst_div1", 64'(result1), 64'd2);
        valid = 1'b0;

        // Low-word carry into the high word
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        valid = 1'b1; sysop = OpRdcycle;
        tick;
        check("carry_lo", 64'(result), 64'h0000_0000_FFFF_FFFF);
        sysop = OpRdcycleh;
        tick;
        check("carry_hi", 64'(result), 64'd1);
        sysop = OpRdcycle;
        tick;
        check("carry_lo_after", 64'(result), 64'd1);
        valid = 1'b0;

`ifdef SYSUNIT_INHIBIT_EN
        rst = 1'b1;
        tick;
        rst = 1'b0; inhibit = 3'b001;
        repeat (20) tick;
        valid = 1'b1; sysop = OpRdcycle;
        tick;
        check("inhibit_cycle_frozen", 64'(result), 64'd0);
        sysop = OpRdtime;
        tick;
        check("inhibit_time_runs_div1", 64'(result1), 64'd21);
        check("inhibit_time_runs_div4", 64'(result), 64'd5);
        valid = 1'b0; inhibit = 3'b000;
        tick;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
